// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared NES register constants and OAM DMA state encoding

package nes_pkg;

    localparam logic [2:0]  PPU_REG_OAMDATA = 3'd4;
    localparam logic [15:0] DMA_REG_ADDR    = 16'h4014;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } oam_dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - CPU-domain OAM DMA: halts the CPU and copies one 256-byte page into PPU OAMDATA

module oam_dma
    import nes_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REG_WR,
    input  logic [7:0]  REG_DATA,
    output logic        CPU_RDY,
    output logic        BUSY,
    output logic [15:0] MEM_ADDR,
    output logic        MEM_RDEN,
    input  logic [7:0]  MEM_DATA,
    output logic [2:0]  PPU_REG_ADDR,
    output logic [7:0]  PPU_REG_DATA,
    output logic        PPU_REG_WREN
);

    oam_dma_state_t state_q, state_d;
    logic           parity_q;
    logic [7:0]     idx_q, idx_d;
    logic [7:0]     page_q, page_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            parity_q <= 1'b0;
            idx_q    <= 8'h00;
            page_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            parity_q <= ~parity_q;
            idx_q    <= idx_d;
            page_q   <= page_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        case (state_q)
            IDLE: begin
                if (REG_WR) begin
                    page_d  = REG_DATA;
                    idx_d   = 8'h00;
                    state_d = HALT;
                end
            end
            // The first READ must land on an even cycle; parity_q=1 now means 0 next.
            HALT:  state_d = parity_q ? READ : ALIGN;
            ALIGN: state_d = READ;
            READ:  state_d = WRITE;
            WRITE: begin
                if (idx_q == 8'hFF) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        BUSY         = (state_q != IDLE);
        CPU_RDY      = (state_q == IDLE);
        MEM_RDEN     = 1'b0;
        MEM_ADDR     = 16'h0000;
        PPU_REG_WREN = 1'b0;
        PPU_REG_ADDR = 3'd0;
        PPU_REG_DATA = 8'h00;
        if (state_q == READ) begin
            MEM_RDEN = 1'b1;
            MEM_ADDR = {page_q, idx_q};
        end
        if (state_q == WRITE) begin
            PPU_REG_WREN = 1'b1;
            PPU_REG_ADDR = PPU_REG_OAMDATA;
            PPU_REG_DATA = MEM_DATA;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - directed self-checking bench for oam_dma

`define CHK(tag, obs, exp) \
    begin \
        n_cmp++; \
        assert ((obs) === (exp)) else begin \
            n_fail++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_oam_dma;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        REG_WR = 1'b0;
    logic [7:0]  REG_DATA = 8'h00;
    logic        CPU_RDY;
    logic        BUSY;
    logic [15:0] MEM_ADDR;
    logic        MEM_RDEN;
    logic [7:0]  MEM_DATA = 8'h00;
    logic [2:0]  PPU_REG_ADDR;
    logic [7:0]  PPU_REG_DATA;
    logic        PPU_REG_WREN;

    oam_dma dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .REG_WR       (REG_WR),
        .REG_DATA     (REG_DATA),
        .CPU_RDY      (CPU_RDY),
        .BUSY         (BUSY),
        .MEM_ADDR     (MEM_ADDR),
        .MEM_RDEN     (MEM_RDEN),
        .MEM_DATA     (MEM_DATA),
        .PPU_REG_ADDR (PPU_REG_ADDR),
        .PPU_REG_DATA (PPU_REG_DATA),
        .PPU_REG_WREN (PPU_REG_WREN)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic        tb_par = 1'b0;
    logic        pend_rd = 1'b0;
    logic [15:0] pend_addr = 16'h0000;
    logic [7:0]  exp_page = 8'h00;
    int          busy_cnt, wr_cnt, rd_cnt, data_err, addr_err, b2b;
    logic        prev_wren;
    logic        first_rd_par;
    logic [15:0] first_rd_addr, last_rd_addr;

    task automatic clr_stats();
        busy_cnt = 0; wr_cnt = 0; rd_cnt = 0; data_err = 0; addr_err = 0; b2b = 0;
        prev_wren = 1'b0; first_rd_par = 1'b1;
        first_rd_addr = 16'h0000; last_rd_addr = 16'h0000;
    endtask

    // One clock: memory model answers the previous cycle's read, then outputs are sampled.
    task automatic cycle();
        @(posedge CLK);
        #1;
        tb_par   = RESET ? 1'b0 : ~tb_par;
        MEM_DATA = pend_rd ? (pend_addr[7:0] ^ 8'h5A) : 8'h00;
        #1;
        if (BUSY) busy_cnt++;
        if (MEM_RDEN) begin
            if (rd_cnt == 0) begin
                first_rd_par  = tb_par;
                first_rd_addr = MEM_ADDR;
            end
            if (rd_cnt > 255 || MEM_ADDR != {exp_page, 8'(rd_cnt)}) addr_err++;
            last_rd_addr = MEM_ADDR;
            rd_cnt++;
        end
        if (PPU_REG_WREN) begin
            if (PPU_REG_ADDR != 3'd4 || PPU_REG_DATA != (8'(wr_cnt) ^ 8'h5A)) data_err++;
            if (prev_wren) b2b++;
            wr_cnt++;
        end
        prev_wren = PPU_REG_WREN;
        pend_rd   = MEM_RDEN;
        pend_addr = MEM_ADDR;
    endtask

    task automatic start(input logic [7:0] page);
        clr_stats();
        exp_page = page;
        REG_DATA = page;
        REG_WR   = 1'b1;
        cycle();
        REG_WR   = 1'b0;
    endtask

    task automatic finish(input int inj, input int stop_wr);
        for (int k = 1; k < 700 && BUSY; k++) begin
            if (k == inj) begin
                REG_WR   = 1'b1;
                REG_DATA = 8'h07;
            end
            cycle();
            REG_WR = 1'b0;
            if (stop_wr != 0 && wr_cnt == stop_wr) break;
        end
        if (stop_wr == 0) `CHK("xfer_done", BUSY, 1'b0)
    endtask

    task automatic check_full(input string tag, input logic [7:0] page);
        `CHK({tag, "_writes"}, wr_cnt, 256)
        `CHK({tag, "_reads"}, rd_cnt, 256)
        `CHK({tag, "_data"}, data_err, 0)
        `CHK({tag, "_addr"}, addr_err, 0)
        `CHK({tag, "_b2b"}, b2b, 0)
        `CHK({tag, "_first_addr"}, first_rd_addr, {page, 8'h00})
        `CHK({tag, "_last_addr"}, last_rd_addr, {page, 8'hFF})
    endtask

    initial begin
        int gap;
        clr_stats();
        RESET = 1'b1;
        cycle();
        cycle();
        RESET = 1'b0;
        `CHK("rst_cpu_rdy", CPU_RDY, 1'b1)
        `CHK("rst_busy", BUSY, 1'b0)
        `CHK("rst_rden", MEM_RDEN, 1'b0)
        `CHK("rst_wren", PPU_REG_WREN, 1'b0)
        `CHK("rst_mem_addr", MEM_ADDR, 16'h0000)
        `CHK("rst_ppu_addr", PPU_REG_ADDR, 3'd0)
        `CHK("rst_ppu_data", PPU_REG_DATA, 8'h00)
        `CHK("rst_parity", tb_par, 1'b0)

        // Strobe in an even cycle: no ALIGN, 513 busy cycles.
        start(8'h02);
        `CHK("t1_halt_busy", BUSY, 1'b1)
        `CHK("t1_halt_rdy", CPU_RDY, 1'b0)
        `CHK("t1_halt_par", tb_par, 1'b1)
        finish(0, 0);
        `CHK("t1_busy_cnt", busy_cnt, 513)
        `CHK("t1_first_rd_par", first_rd_par, 1'b0)
        `CHK("t1_idle_rdy", CPU_RDY, 1'b1)
        check_full("t1", 8'h02);

        // Strobe in an odd cycle: ALIGN inserted, 514 busy cycles.
        if (tb_par == 1'b0) cycle();
        start(8'h02);
        finish(0, 0);
        `CHK("t2_busy_cnt", busy_cnt, 514)
        `CHK("t2_first_rd_par", first_rd_par, 1'b0)
        check_full("t2", 8'h02);

        // Stray strobe mid-transfer is ignored.
        start(8'h02);
        finish(100, 0);
        check_full("t3", 8'h02);

        // Reset after the 40th PPU write abandons the copy.
        start(8'h05);
        finish(0, 40);
        `CHK("t4_wr_before_rst", wr_cnt, 40)
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
        `CHK("t4_rst_rdy", CPU_RDY, 1'b1)
        `CHK("t4_rst_busy", BUSY, 1'b0)
        for (int i = 0; i < 5; i++) cycle();
        `CHK("t4_no_more_wr", wr_cnt, 40)
        start(8'h03);
        finish(0, 0);
        check_full("t4b", 8'h03);

        // Top page: last read at FFFF, no wrap to 0000.
        start(8'hFF);
        finish(0, 0);
        check_full("t5", 8'hFF);
        for (int i = 0; i < 3; i++) cycle();
        `CHK("t5_no_wrap_read", rd_cnt, 256)

        // Back-to-back transfers with a two-cycle CPU_RDY gap.
        start(8'h01);
        finish(0, 0);
        check_full("t6a", 8'h01);
        gap = 0;
        if (CPU_RDY) gap++;
        cycle();
        if (CPU_RDY) gap++;
        start(8'h04);
        `CHK("t6_gap", gap, 2)
        `CHK("t6_halt_rdy", CPU_RDY, 1'b0)
        finish(0, 0);
        check_full("t6b", 8'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
